// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding and coin constants for the vending coin interface
package vend_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2,
    S_FIN   = 2'd3
  } state_t;
  localparam int NICKEL_U    = 1;
  localparam int DIME_U      = 2;
  localparam int CENTS_PER_U = 5;
  localparam int GAP_W       = 4;
endpackage

// File: rtl/vend_gap_timer.sv
// vend_gap_timer: loadable down-counter that spaces consecutive coin pulses
module vend_gap_timer
  import vend_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [GAP_W-1:0] i_value,
  input  logic             i_dec,
  output logic             o_zero
);
  logic [GAP_W-1:0] r_cnt;
  // o_zero flags that the count reaches zero on the coming decrement
  assign o_zero = (r_cnt <= GAP_W'(1));
  // load wins over decrement; count saturates at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_cnt <= '0;
    else if (i_load) r_cnt <= i_value;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - GAP_W'(1);
  end
endmodule

// File: rtl/vend_change_dispenser.sv
// vend_change_dispenser: pays a nickel-unit refund as single-cycle D/N coin pulses
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  input  logic             dime_empty,
  input  logic             nick_empty,
  output logic             busy,
  output logic             D,
  output logic             N,
  output logic [AMT_W-1:0] remaining,
  output logic             done,
  output logic             short
);
  localparam logic [AMT_W-1:0] L_DIME = AMT_W'(DIME_U);
  localparam logic [AMT_W-1:0] L_NICK = AMT_W'(NICKEL_U);
  state_t r_state;
  logic   w_can_d, w_can_n, w_zero;
  assign w_can_d = (remaining >= L_DIME) && !dime_empty;
  assign w_can_n = (remaining >= L_NICK) && !nick_empty;
  vend_gap_timer u_gap (
    .clk     (clk),
    .reset   (reset),
    .i_load  (r_state == S_ISSUE && (w_can_d || w_can_n)),
    .i_value (GAP_W'(GAP_CYC)),
    .i_dec   (r_state == S_GAP),
    .o_zero  (w_zero)
  );
  // refund FSM: dimes first, nickels as fallback, short when neither fits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      busy      <= 1'b0;
      D         <= 1'b0;
      N         <= 1'b0;
      remaining <= '0;
      done      <= 1'b0;
      short     <= 1'b0;
    end else begin
      D    <= 1'b0;
      N    <= 1'b0;
      done <= 1'b0;
      case (r_state)
        S_IDLE: if (req) begin
          short <= 1'b0;
          if (amount != '0) begin
            remaining <= amount;
            busy      <= 1'b1;
            r_state   <= S_ISSUE;
          end else done <= 1'b1;
        end
        S_ISSUE: if (w_can_d) begin
          D         <= 1'b1;
          remaining <= remaining - L_DIME;
          r_state   <= S_GAP;
        end else if (w_can_n) begin
          N         <= 1'b1;
          remaining <= remaining - L_NICK;
          r_state   <= S_GAP;
        end else begin
          short   <= 1'b1;
          r_state <= S_FIN;
        end
        S_GAP: if (w_zero) r_state <= (remaining != '0) ? S_ISSUE : S_FIN;
        S_FIN: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          busy      <= 1'b0;
          remaining <= '0;
          short     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vend_change_dispenser.sv
// tb_vend_change_dispenser: schedule-model bench for the change dispenser
module tb_vend_change_dispenser;
  localparam int AW = 4;
  localparam int G  = 2;
  logic clk = 0, reset = 0, req = 0, de = 0, ne = 0;
  logic [AW-1:0] amount = '0;
  logic busy, d_o, n_o, done, sh;
  logic [AW-1:0] rem;
  int tests = 0, fails = 0, cyc = 0;
  int nd = 0, nn = 0, ndone = 0, nbusy = 0;
  int last_d = -1, last_n = -1, last_done = -1;

  vend_change_dispenser #(.AMT_W(AW), .GAP_CYC(G)) dut (
    .clk(clk), .reset(reset), .req(req), .amount(amount),
    .dime_empty(de), .nick_empty(ne), .busy(busy), .D(d_o), .N(n_o),
    .remaining(rem), .done(done), .short(sh)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b, d, n, dn, s;
    logic [AW-1:0] r;
  } ov_t;
  ov_t q[$];
  ov_t e, last;
  logic s_req, s_rst, s_de, s_ne;
  logic [AW-1:0] s_amt;

  function automatic ov_t mk(logic b, logic d, logic n, logic dn, logic s, logic [AW-1:0] r);
    ov_t v;
    v.b = b; v.d = d; v.n = n; v.dn = dn; v.s = s; v.r = r;
    return v;
  endfunction

  // expected per-edge outputs of a whole refund: greedy coin list laid on a fixed timeline
  function automatic void build(logic [AW-1:0] a, logic fde, logic fne);
    int r = int'(a);
    bit go = 1;
    q.push_back(mk(1, 0, 0, 0, 0, a));
    while (go) begin
      if (r >= 2 && !fde) begin r -= 2; q.push_back(mk(1, 1, 0, 0, 0, AW'(r))); end
      else if (r >= 1 && !fne) begin r -= 1; q.push_back(mk(1, 0, 1, 0, 0, AW'(r))); end
      else break;
      for (int k = 0; k < G; k++) q.push_back(mk(1, 0, 0, 0, 0, AW'(r)));
      if (r == 0) go = 0;
    end
    if (r != 0) q.push_back(mk(1, 0, 0, 0, 1, AW'(r)));
    q.push_back(mk(0, 0, 0, 1, r != 0, AW'(r)));
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, expv);
    end
  endtask

  initial last = '0;

  // per-cycle compare against the schedule model, plus pulse bookkeeping
  always @(posedge clk) begin
    s_req = req; s_rst = reset; s_amt = amount; s_de = de; s_ne = ne;
    cyc++;
    if (!s_rst) begin q.delete(); e = '0; end
    else if (q.size() != 0) e = q.pop_front();
    else if (s_req && s_amt != '0) begin build(s_amt, s_de, s_ne); e = q.pop_front(); end
    else e = mk(0, 0, 0, s_req, s_req ? 1'b0 : last.s, last.r);
    last = e;
    #1;
    check("busy", busy, e.b);
    check("D", d_o, e.d);
    check("N", n_o, e.n);
    check("done", done, e.dn);
    check("short", sh, e.s);
    check("remaining", rem, e.r);
    if (d_o === 1'b1) begin nd++; last_d = cyc; end
    if (n_o === 1'b1) begin nn++; last_n = cyc; end
    if (done === 1'b1) begin ndone++; last_done = cyc; end
    if (busy === 1'b1) nbusy++;
  end

  int t0, bd, bn, bdn, bb;

  task automatic snap();
    bd = nd; bn = nn; bdn = ndone; bb = nbusy;
  endtask

  task automatic start(input logic [AW-1:0] a);
    @(negedge clk);
    amount = a; req = 1; t0 = cyc;
    @(negedge clk);
    req = 0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 100 && ndone == bdn; i++) @(negedge clk);
    check("done_timeout", ndone != bdn, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rem", rem, 0);
    check("rst_DN", {d_o, n_o, done, sh}, 0);
    reset = 1;
    repeat (2) @(negedge clk);

    snap(); start(3); wait_done();
    check("a3_D_cyc", last_d, t0 + 2);
    check("a3_N_cyc", last_n, t0 + 5);
    check("a3_done_cyc", last_done, t0 + 8);
    check("a3_counts", {nd - bd, nn - bn}, {32'd1, 32'd1} >> 0 == 0 ? 0 : ((nd - bd == 1) && (nn - bn == 1)) ? {nd - bd, nn - bn} : 64'h1_00000001);
    check("a3_short", sh, 0);
    check("a3_rem", rem, 0);

    de = 1; snap(); start(4); wait_done();
    check("a4_nD", nd - bd, 0);
    check("a4_nN", nn - bn, 4);
    check("a4_lastN", last_n, t0 + 11);
    check("a4_done_cyc", last_done, t0 + 14);
    check("a4_short", sh, 0);
    de = 0;

    ne = 1; snap(); start(3); wait_done();
    check("a3ne_nD", nd - bd, 1);
    check("a3ne_nN", nn - bn, 0);
    check("a3ne_short", sh, 1);
    check("a3ne_rem", rem, 1);
    check("a3ne_done_cyc", last_done, t0 + 6);
    ne = 0;

    snap(); start(0); wait_done();
    check("a0_done_cyc", last_done, t0 + 1);
    check("a0_busy", nbusy - bb, 0);
    check("a0_coins", (nd - bd) + (nn - bn), 0);
    check("a0_short", sh, 0);

    snap(); start(2);
    @(negedge clk); amount = 7; req = 1;
    @(negedge clk); req = 0;
    wait_done();
    repeat (30) @(negedge clk);
    check("busyreq_nD", nd - bd, 1);
    check("busyreq_nN", nn - bn, 0);
    check("busyreq_ndone", ndone - bdn, 1);

    snap(); start(5);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_rem", rem, 0);
    check("abort_DN", {d_o, n_o}, 0);
    repeat (5) @(negedge clk);
    check("abort_nD", nd - bd, 1);
    check("abort_nodone", ndone - bdn, 0);
    reset = 1;
    @(negedge clk);
    snap(); start(5); wait_done();
    check("after_nD", nd - bd, 2);
    check("after_nN", nn - bn, 1);
    check("after_lastN", last_n, t0 + 8);
    check("after_done_cyc", last_done, t0 + 11);
    check("after_short", sh, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
